demux4_reg: RTL and testbench

Registered 1-to-4 demultiplexer with valid/ready handshakes: routes each 16-bit input word to one of four output channels selected by a 2-bit `sel`, the write-side counterpart of the team's 4:1 selector tree. Each channel holds one word in an output register until its consumer takes it. It sits between a single producer (ALU/bus result) and four destination ports (register banks or peripherals). Channels are independent, so a stalled channel does not block the other three.

---
 rtl/demux4_reg_pkg.sv | 14 +
 rtl/demux4_reg_if.sv | 24 ++
 rtl/demux_slot.sv | 36 +++
 rtl/demux4_reg.sv | 59 +++++
 tb/tb_demux4_reg.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/demux4_reg_pkg.sv
// Shared constants and channel-select type for the registered 1-to-4 demultiplexer.
package demux4_reg_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NCH   = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    function automatic logic [NCH-1:0] sel_onehot(input ch_sel_t sel);
        return NCH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux4_reg_if.sv
// Producer-side and consumer-side handshake bundle for demux4_reg.
interface demux4_reg_if;
    import demux4_reg_pkg::*;

    logic [WIDTH-1:0]     in_data;
    ch_sel_t              in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [7:0]           acc_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, acc_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, acc_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// One output channel: a single-word holding register with a full flag.
module demux_slot #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             ready_i,
    input  logic [Width-1:0] data_i,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_d, full_q;
    logic [Width-1:0] data_d, data_q;

    // A push on the same edge as a pop keeps the slot full with the new word.
    always_comb begin
        full_d = push_i | (full_q & ~ready_i);
        data_d = push_i ? data_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer; each channel stalls independently of the others.
module demux4_reg
    import demux4_reg_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    demux4_reg_if.slave  bus
);

    ch_sel_t        sel;
    logic           in_fire;
    logic [NCH-1:0] push;
    logic [NCH-1:0] full;
    logic [7:0]     acc_cnt_d, acc_cnt_q;

    assign sel = bus.in_sel;

    // Ready looks only at the addressed channel so a stalled channel blocks nothing else.
    assign bus.in_ready = rst_n & (~full[sel] | bus.out_ready[sel]);
    assign in_fire      = bus.in_valid & bus.in_ready;

    always_comb begin
        push = '0;
        if (in_fire) begin
            push = sel_onehot(sel);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .Width (WIDTH)
        ) u_slot (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .push_i  (push[k]),
            .ready_i (bus.out_ready[k]),
            .data_i  (bus.in_data),
            .full_o  (full[k]),
            .data_o  (bus.out_data[k*WIDTH +: WIDTH])
        );
    end

    assign bus.out_valid = full;

    always_comb begin
        acc_cnt_d = acc_cnt_q + {7'd0, in_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= 8'd0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign bus.acc_cnt = acc_cnt_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed bench for demux4_reg with a per-channel scoreboard of expected words.
module tb_demux4_reg;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [15:0] sb [4][$];
    logic [7:0]  model_cnt;

    demux4_reg_if bus ();

    demux4_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set; scores pops/pushes and advances one edge.
    task automatic cycle();
        logic [3:0]  exp_valid;
        logic        exp_rdy;
        logic [15:0] exp_word;
        int          s;
        #1;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) exp_valid[k] = (sb[k].size() != 0);
            chk("out_valid", {60'd0, bus.out_valid}, {60'd0, exp_valid});
            s = int'(bus.in_sel);
            exp_rdy = (sb[s].size() == 0) || bus.out_ready[s];
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
            for (int k = 0; k < 4; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        chk("pop_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_word = sb[k].pop_front();
                        chk("pop_data", {48'd0, bus.out_data[k*16 +: 16]}, {48'd0, exp_word});
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb[s].push_back(bus.in_data);
                model_cnt = model_cnt + 8'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        errors    = 0;
        checks    = 0;
        model_cnt = 8'd0;
        bus.in_data   = 16'h0;
        bus.in_sel    = 2'd0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 4'b0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset with a valid offer pending
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {60'd0, bus.out_valid}, 64'd0);
        chk("rst_acc_cnt", {56'd0, bus.acc_cnt}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Routing to all four channels with consumers stalled
        for (int i = 0; i < 4; i++) begin
            bus.in_sel  = 2'(i);
            bus.in_data = 16'h1111 * 16'(i + 1);
            cycle();
            chk("route_valid", {60'd0, bus.out_valid}, {60'd0, 4'((1 << (i + 1)) - 1)});
            chk("route_data", {48'd0, bus.out_data[i*16 +: 16]}, {48'd0, 16'h1111 * 16'(i + 1)});
        end
        bus.in_sel  = 2'd2;
        bus.in_data = 16'h5555;
        #1;
        chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
        cycle();
        chk("route_acc_cnt", {56'd0, bus.acc_cnt}, 64'd4);

        // Drain, then pass-through on a full channel
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        cycle();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 16'hAAAA;
        cycle();
        bus.out_ready = 4'b0010;
        bus.in_data   = 16'hBBBB;
        #1;
        chk("pt_in_ready", {63'd0, bus.in_ready}, 64'd1);
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        #1;
        chk("pt_data", {48'd0, bus.out_data[31:16]}, {48'd0, 16'hBBBB});
        chk("pt_valid", {63'd0, bus.out_valid[1]}, 64'd1);

        // Independence: ch0 stalled while ch3 streams
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 16'h1234;
        cycle();
        bus.out_ready = 4'b1000;
        bus.in_sel    = 2'd3;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 16'hC000 + 16'(i);
            #1;
            chk("ind_in_ready", {63'd0, bus.in_ready}, 64'd1);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("ind_ch0_data", {48'd0, bus.out_data[15:0]}, {48'd0, 16'h1234});
        chk("ind_ch0_valid", {63'd0, bus.out_valid[0]}, 64'd1);
        chk("ind_acc_cnt", {56'd0, bus.acc_cnt}, {56'd0, model_cnt});

        // Counter wrap with idle cycles interleaved
        bus.out_ready = 4'b1111;
        cycle();
        n = 0;
        while (model_cnt != 8'd0 && n < 1000) begin
            bus.in_valid = (n % 3 != 2);
            bus.in_sel   = 2'(n % 4);
            bus.in_data  = 16'($urandom);
            cycle();
            n++;
        end
        chk("wrap_bound", {63'd0, n >= 1000}, 64'd0);
        chk("wrap_acc_cnt", {56'd0, bus.acc_cnt}, 64'd0);

        // Mid-operation reset with two channels full
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b0;
        cycle();
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 16'hDEAD;
        cycle();
        bus.in_sel  = 2'd2;
        bus.in_data = 16'hBEEF;
        cycle();
        bus.in_valid = 1'b0;
        chk("mr_valid_pre", {60'd0, bus.out_valid}, 64'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid_async", {60'd0, bus.out_valid}, 64'd0);
        chk("mr_data_async", bus.out_data, 64'd0);
        chk("mr_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        model_cnt = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        cycle();
        chk("mr_valid_post", {60'd0, bus.out_valid}, 64'd0);
        chk("mr_data_post", bus.out_data, 64'd0);
        chk("mr_acc_cnt", {56'd0, bus.acc_cnt}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
